fifo_rd_streamer: RTL
=====================

Name: fifo_rd_streamer

Overview:
Read-side drain engine for the async FIFO. It sits in the read clock domain and turns the FIFO pop interface (rd_en / dout / empty) into a valid/ready stream for downstream logic. It tracks the FIFO's fixed read latency with in-flight tags and buffers returned words in a small circular buffer, so back-pressure never loses data. A synchronous flush discards buffered and in-flight words.

Parameters:
- DATA_WIDTH, 8, word width; must match the FIFO.
- RD_LATENCY, 1, rd_en-to-dout latency of the FIFO in clk cycles; legal range 1..3.
- Derived localparam BUF_DEPTH = RD_LATENCY+2: number of skid buffer entries.
- Derived localparam CNT_W = $clog2(BUF_DEPTH+1): width of the entry counter.

Ports:
- clk  input  1  read-domain clock; all logic on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous request to drop all buffered and in-flight data.
- fifo_empty  input  1  FIFO empty flag.
- fifo_dout  input  DATA_WIDTH  FIFO read data, valid RD_LATENCY cycles after an accepted rd_en.
- fifo_rd_en  output  1  pop request to the FIFO.
- m_data  output  DATA_WIDTH  stream data.
- m_valid  output  1  stream data valid.
- m_ready  input  1  downstream accept.
- busy  output  1  asserted when the block is flushing, has reads in flight, or m_valid is high.

Behaviour:
- Reset (rst_n=0, asynchronous): state=RUN, buffer empty, in-flight tag shift register cleared.
  - fifo_rd_en=0, m_valid=0, m_data=0, busy=0.
- fifo_rd_en = (state==RUN) && !flush && !fifo_empty && (buf_cnt + inflight_cnt < BUF_DEPTH).
  - Purely registered terms plus fifo_empty/flush; no combinational path from m_ready.
- Each cycle, tag shift register [RD_LATENCY-1:0] shifts in fifo_rd_en; inflight_cnt = popcount of tags.
  - When the oldest tag is 1, fifo_dout is written to the buffer tail at that edge (state RUN only).
- Latency: fifo_rd_en high in cycle t -> word captured at end of cycle t+RD_LATENCY -> m_valid high in cycle t+RD_LATENCY+1.
- Throughput: one word per cycle sustained while the FIFO is non-empty and m_ready=1.
- Handshake: transfer on m_valid && m_ready.
  - m_data and m_valid hold stable while m_valid && !m_ready.
  - m_data = buffer head; m_valid = (buf_cnt != 0).
- Simultaneous write and pop: buf_cnt unchanged; head and tail both advance. Pointers wrap modulo BUF_DEPTH.
- The credit rule guarantees no buffer overflow. If a write would occur with buf_cnt==BUF_DEPTH, that is a design error; the bench flags it with an assertion.
- FSM:
  - RUN: flush=1 -> next FLUSH. At that edge: buffer cleared, m_valid low next cycle, no capture.
  - FLUSH:
    - fifo_rd_en=0; returning words are discarded.
    - Exit to RUN when flush=0 && inflight_cnt==0, evaluated each cycle.
    - Minimum one cycle in FLUSH.
- A flush concurrent with m_valid&&m_ready: the transfer completes, then the buffer clears.
- Reset mid-operation: immediate return to reset values; in-flight words are lost. The FIFO must be reset together with this block.

Optional Feature:
- Macro FIFO_RD_STATS_EN.
- Defined:
  - Adds output word_cnt [31:0]: increments on each m_valid&&m_ready and wraps at 2^32.
  - Adds output drop_cnt [15:0]: increments by the number of words discarded by flush (buffered + returned-in-flush) and saturates at 0xFFFF.
  - Both counters are cleared by rst_n only.
- Undefined: the ports and counters do not exist; function is otherwise identical.

Decomposition:
- Shared package fifo_stream_pkg holds:
  - state typedef {RUN, FLUSH};
  - MAX_RD_LATENCY=3;
  - function calc_buf_depth(lat)=lat+2.
- Sub-module stream_skid_buf(DATA_WIDTH, DEPTH) contains the circular buffer, head/tail/count, and push/pop/clear.
- The top module holds the FSM, tag shift register, credit logic and optional stats.

Test Plan:
- RD_LATENCY=1, FIFO preloaded with 0x11,0x22,0x33, m_ready=1 -> fifo_rd_en cycles 0-2; m_data 0x11/0x22/0x33 with m_valid in cycles 2-4; busy=0 by cycle 5.
- m_ready=0 with 10 words queued -> exactly 3 fifo_rd_en pulses; m_valid held with m_data=first word. Release m_ready -> 10 words out in order, no gaps after the first.
- RD_LATENCY=3, continuous stream of 20 words, m_ready=1 -> 20 consecutive beats; buffer count never exceeds 5.
- flush pulse for 1 cycle with 2 buffered and 1 in flight -> m_valid=0 next cycle; the in-flight word is not emitted; RUN resumes after the tag clears; the next word emitted is the next FIFO entry. With FIFO_RD_STATS_EN, drop_cnt=3.
- rst_n asserted low mid-stream (asynchronously, between edges) -> fifo_rd_en, m_valid, busy go 0 immediately. After release with a fresh FIFO, normal operation.
- fifo_empty toggling every cycle with random m_ready, 1000 words -> output order matches input; no loss or duplication; word_cnt=1000.

Source files
------------

// File: rtl/fifo_stream_pkg.sv
// Shared types and sizing helpers for the FIFO read-side streamer.
package fifo_stream_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } stream_state_e;

    localparam int unsigned MAX_RD_LATENCY = 3;

    // One entry per in-flight read plus two to keep a full-rate stream under back-pressure.
    function automatic int unsigned calc_buf_depth(input int unsigned lat);
        return lat + 2;
    endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Circular skid buffer with head/tail pointers, occupancy count, push/pop and synchronous clear.
module stream_skid_buf
    import fifo_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear_i,
    input  logic                          push_i,
    input  logic [DATA_WIDTH-1:0]         push_data_i,
    input  logic                          pop_i,
    output logic [DATA_WIDTH-1:0]         head_data_o,
    output logic [$clog2(DEPTH+1)-1:0]    cnt_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      head_q, tail_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    always_comb begin
        cnt_d = cnt_q;
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (clear_i) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[tail_q] <= push_data_i;
                tail_q        <= ptr_inc(tail_q);
            end
            if (pop_i) head_q <= ptr_inc(head_q);
            cnt_q <= cnt_d;
        end
    end

    assign head_data_o = mem_q[head_q];
    assign cnt_o       = cnt_q;

endmodule

// File: rtl/fifo_rd_streamer.sv
// Drains an async FIFO's pop interface into a valid/ready stream with credit-based skid buffering.
// Optional FIFO_RD_STATS_EN adds word_cnt/drop_cnt statistics outputs.
module fifo_rd_streamer
    import fifo_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [31:0]           word_cnt,
    output logic [15:0]           drop_cnt
`endif
);

    localparam int unsigned BUF_DEPTH = calc_buf_depth(RD_LATENCY);
    localparam int unsigned CNT_W     = $clog2(BUF_DEPTH + 1);

    stream_state_e         state_q;
    logic [RD_LATENCY-1:0] tag_q, tag_d;
    logic [CNT_W-1:0]      inflight_cnt, buf_cnt;
    logic                  credit_ok, oldest_tag;
    logic                  buf_push, buf_pop, buf_clear;

    always_comb begin
        inflight_cnt = '0;
        for (int unsigned i = 0; i < RD_LATENCY; i++) begin
            inflight_cnt = inflight_cnt + CNT_W'(tag_q[i]);
        end
    end

    // Reads are only issued when every outstanding word already has a buffer slot.
    assign credit_ok  = ({1'b0, buf_cnt} + {1'b0, inflight_cnt}) < (CNT_W + 1)'(BUF_DEPTH);
    assign fifo_rd_en = (state_q == RUN) && !flush && !fifo_empty && credit_ok;
    assign oldest_tag = tag_q[RD_LATENCY-1];

    assign buf_clear  = (state_q == RUN) && flush;
    assign buf_push   = (state_q == RUN) && !flush && oldest_tag;
    assign buf_pop    = m_valid && m_ready;

    always_comb begin
        tag_d    = '0;
        tag_d[0] = fifo_rd_en;
        for (int unsigned i = 1; i < RD_LATENCY; i++) tag_d[i] = tag_q[i-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            tag_q   <= '0;
        end else begin
            tag_q <= tag_d;
            case (state_q)
                RUN:     if (flush) state_q <= FLUSH;
                FLUSH:   if (!flush && (inflight_cnt == '0)) state_q <= RUN;
                default: state_q <= RUN;
            endcase
        end
    end

    stream_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (buf_clear),
        .push_i      (buf_push),
        .push_data_i (fifo_dout),
        .pop_i       (buf_pop),
        .head_data_o (m_data),
        .cnt_o       (buf_cnt)
    );

    assign m_valid = (buf_cnt != '0);
    assign busy    = (state_q == FLUSH) || (inflight_cnt != '0) || m_valid;

`ifdef FIFO_RD_STATS_EN
    logic [31:0] word_cnt_q;
    logic [15:0] drop_cnt_q, drop_inc;
    logic [16:0] drop_sum;

    // Dropped words: buffer contents not popped at the flush edge, plus any word returning
    // while the capture path is blocked.
    always_comb begin
        drop_inc = '0;
        if (buf_clear) drop_inc = 16'(buf_cnt) - 16'(buf_pop);
        if (oldest_tag && !buf_push) drop_inc = drop_inc + 16'd1;
        drop_sum = {1'b0, drop_cnt_q} + {1'b0, drop_inc};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (buf_pop) word_cnt_q <= word_cnt_q + 32'd1;
            drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    assign word_cnt = word_cnt_q;
    assign drop_cnt = drop_cnt_q;
`endif

endmodule
